// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the 5-stage MIPS hazard logic:
//            forwarding-select codes, sequencer state enum, shadow entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Memory sequencer state
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } st_e;

  // Shadow copy of one in-flight instruction
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       regwrite;
    logic       memread;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // MEM result is younger than WB, so it wins when both write the register
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_match.sv
// ============================================================================
// Module   : reg_match
// Brief    : Register-number compare of a producer against a source operand.
//            Register $0 is hard-wired to zero and never matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_match (
  input  logic       valid_i,
  input  logic       wen_i,
  input  logic [4:0] wr_i,
  input  logic [4:0] src_i,
  output logic       match_o
);

  assign match_o = valid_i & wen_i & (wr_i != 5'd0) & (wr_i == src_i);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline sequencing controller. Tracks EX/MEM/WB destinations,
//            produces PC / IF-ID enables, bubbles, flushes, forwarding
//            selects, freezes on data-memory wait, counts stalls and flags
//            memory timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_wr_reg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_take,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int HCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [HCNT_W-1:0] C_TIMEOUT = HCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d;

  st_e               st_q;
  logic [HCNT_W-1:0] hold_cnt_q;
  logic [HCNT_W-1:0] w_hold_inc;
  logic              w_hold_hit;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic w_lu_rs, w_lu_rt, w_lu;
  logic w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
  logic w_unused;

  // ---------------------------------------------------------------------------
  // Load-use detection: ID reads the destination of a load currently in EX
  // ---------------------------------------------------------------------------
  reg_match u_lu_rs (
    .valid_i (id_valid & id_use_rs & ex_q.valid),
    .wen_i   (ex_q.memread),
    .wr_i    (ex_q.wr),
    .src_i   (id_rs),
    .match_o (w_lu_rs)
  );

  reg_match u_lu_rt (
    .valid_i (id_valid & id_use_rt & ex_q.valid),
    .wen_i   (ex_q.memread),
    .wr_i    (ex_q.wr),
    .src_i   (id_rt),
    .match_o (w_lu_rt)
  );

  assign w_lu = w_lu_rs | w_lu_rt;

  // ---------------------------------------------------------------------------
  // Forwarding compares: EX sources against MEM and WB producers
  // ---------------------------------------------------------------------------
  reg_match u_mem_rs (
    .valid_i (mem_q.valid),
    .wen_i   (mem_q.regwrite),
    .wr_i    (mem_q.wr),
    .src_i   (ex_q.rs),
    .match_o (w_mem_rs)
  );

  reg_match u_mem_rt (
    .valid_i (mem_q.valid),
    .wen_i   (mem_q.regwrite),
    .wr_i    (mem_q.wr),
    .src_i   (ex_q.rt),
    .match_o (w_mem_rt)
  );

  reg_match u_wb_rs (
    .valid_i (wb_q.valid),
    .wen_i   (wb_q.regwrite),
    .wr_i    (wb_q.wr),
    .src_i   (ex_q.rs),
    .match_o (w_wb_rs)
  );

  reg_match u_wb_rt (
    .valid_i (wb_q.valid),
    .wen_i   (wb_q.regwrite),
    .wr_i    (wb_q.wr),
    .src_i   (ex_q.rt),
    .match_o (w_wb_rt)
  );

  assign fwd_a = rst ? FWD_REG : fwd_sel(w_mem_rs, w_wb_rs);
  assign fwd_b = rst ? FWD_REG : fwd_sel(w_mem_rt, w_wb_rt);

  // Enable / flush priority: reset, memory wait, taken branch, load-use, run
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_en    = 1'b1;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_en    = 1'b0;
    end else if (!mem_ready) begin
      // Whole pipe freezes; a taken branch in EX simply waits in place
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      pipe_en = 1'b0;
    end else if (ex_take) begin
      // The ID instruction is squashed, so any load-use on it is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next EX entry: ID fields, demoted to a bubble by clearing valid only
  always_comb begin
    ex_d          = SHADOW_EMPTY;
    ex_d.valid    = id_valid & ~idex_flush;
    ex_d.rs       = id_rs;
    ex_d.rt       = id_rt;
    ex_d.wr       = id_wr_reg;
    ex_d.regwrite = id_regwrite;
    ex_d.memread  = id_memread;
  end

  // Shadow pipeline advances in lockstep with the real pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= SHADOW_EMPTY;
      mem_q <= SHADOW_EMPTY;
      wb_q  <= SHADOW_EMPTY;
    end else if (pipe_en) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Saturating increment of the consecutive wait counter
  assign w_hold_inc = (hold_cnt_q == C_TIMEOUT) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign w_hold_hit = (w_hold_inc == C_TIMEOUT);

  // Memory-wait sequencer: counts every not-ready cycle, flags the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= RUN;
      hold_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (st_q)
        RUN: begin
          if (!mem_ready) begin
            st_q       <= HOLD;
            hold_cnt_q <= w_hold_inc;
            if (w_hold_hit) begin
              mem_err_q <= 1'b1;
            end
          end else begin
            hold_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (mem_ready) begin
            st_q       <= RUN;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= w_hold_inc;
            if (w_hold_hit) begin
              mem_err_q <= 1'b1;
            end
          end
        end
        default: begin
          st_q       <= RUN;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  // Stall statistics: every non-reset cycle in which the PC is held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_we && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign mem_err   = mem_err_q;

  // WB source fields are carried for visibility only
  assign w_unused = ^{wb_q.rs, wb_q.rt, wb_q.memread};

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: directed scenarios with
//            literal expectations plus randomized traffic, all compared
//            against an in-bench pipeline model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [4:0]       id_rs, id_rt, id_wr_reg;
  logic             ex_take, mem_ready;
  logic             pc_we, ifid_we, ifid_flush, idex_flush, pipe_en, mem_err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_wr_reg  (id_wr_reg),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .ex_take    (ex_take),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .pipe_en    (pipe_en),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall_cnt  (stall_cnt),
    .mem_err    (mem_err)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    int rs, rt, wr;
    bit rw, mr;
  } ent_t;

  ent_t pipe_m [3];   // 0 = EX, 1 = MEM, 2 = WB
  int   m_stall, m_low;
  bit   m_err;
  bit   e_pc, e_ifid, e_ifl, e_idl, e_pen;
  int   e_fa, e_fb;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input ent_t e, input int r);
    return e.v && e.rw && (e.wr != 0) && (e.wr == r);
  endfunction

  function automatic int src_of(input int r);
    if (writes(pipe_m[1], r)) return 2;
    if (writes(pipe_m[2], r)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe_m[i] = '{0, 0, 0, 0, 0, 0};
    m_stall = 0;
    m_low   = 0;
    m_err   = 0;
  endtask

  // Mid-cycle: derive the expected outputs and compare every one of them
  task automatic settle();
    bit lu;
    #4;
    lu = id_valid && pipe_m[0].v && pipe_m[0].mr && (pipe_m[0].wr != 0) &&
         ((id_use_rs && (int'(id_rs) == pipe_m[0].wr)) ||
          (id_use_rt && (int'(id_rt) == pipe_m[0].wr)));
    if (rst)             {e_pc, e_ifid, e_ifl, e_idl, e_pen} = 5'b00110;
    else if (!mem_ready) {e_pc, e_ifid, e_ifl, e_idl, e_pen} = 5'b00000;
    else if (ex_take)    {e_pc, e_ifid, e_ifl, e_idl, e_pen} = 5'b11111;
    else if (lu)         {e_pc, e_ifid, e_ifl, e_idl, e_pen} = 5'b00011;
    else                 {e_pc, e_ifid, e_ifl, e_idl, e_pen} = 5'b11001;
    e_fa = rst ? 0 : src_of(pipe_m[0].rs);
    e_fb = rst ? 0 : src_of(pipe_m[0].rt);
    chk("pc_we",      pc_we,      e_pc);
    chk("ifid_we",    ifid_we,    e_ifid);
    chk("ifid_flush", ifid_flush, e_ifl);
    chk("idex_flush", idex_flush, e_idl);
    chk("pipe_en",    pipe_en,    e_pen);
    chk("fwd_a",      fwd_a,      e_fa);
    chk("fwd_b",      fwd_b,      e_fb);
    chk("stall_cnt",  stall_cnt,  m_stall);
    chk("mem_err",    mem_err,    m_err);
  endtask

  // Clock edge: advance the model with the inputs of the cycle just ended
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_pen) begin
        pipe_m[2] = pipe_m[1];
        pipe_m[1] = pipe_m[0];
        pipe_m[0] = '{id_valid && !e_idl, id_rs, id_rt, id_wr_reg, id_regwrite, id_memread};
      end
      if (!e_pc && m_stall < CNT_MAX) m_stall++;
      if (!mem_ready) begin
        m_low++;
        if (m_low >= MEM_TIMEOUT) m_err = 1;
      end else begin
        m_low = 0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input int wr, input bit rw, input bit mr);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_wr_reg   = 5'(wr);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; ex_take = 0; mem_ready = 1; nop();
    cyc();
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; ex_take = 0; mem_ready = 1; nop();
    model_reset();
    @(posedge clk); #1;

    // Reset state
    settle();
    chk("rst_pc_we", pc_we, 0);
    chk("rst_idex_flush", idex_flush, 1);
    tick();
    rst = 0;
    settle();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_err", mem_err, 0);
    tick();

    // Load-use: lw $8 then add using $8
    do_reset();
    set_id(1, 0, 0, 0, 0, 8, 1, 1); cyc();
    set_id(1, 8, 9, 1, 0, 10, 1, 0);
    settle();
    chk("lu_pc_we", pc_we, 0);
    chk("lu_idex_flush", idex_flush, 1);
    tick();
    settle();
    chk("lu_after_pc_we", pc_we, 1);
    chk("lu_after_fwd_a", fwd_a, 2);
    chk("lu_after_stall", stall_cnt, 1);
    tick();
    nop(); cyc();

    // Double forward: MEM beats WB, WB alone, $0 never forwards
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 3, 1, 0); cyc();
    set_id(1, 3, 3, 1, 1, 4, 1, 0); cyc();
    nop(); settle(); chk("dfw_mem_fwd_a", fwd_a, 2); chk("dfw_mem_fwd_b", fwd_b, 2); tick();
    set_id(1, 0, 0, 0, 0, 3, 1, 0); cyc();
    nop(); cyc();
    set_id(1, 3, 0, 1, 0, 4, 1, 0); cyc();
    nop(); settle(); chk("dfw_wb_fwd_a", fwd_a, 1); tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); cyc();
    set_id(1, 0, 0, 1, 0, 4, 1, 0); cyc();
    nop(); settle(); chk("dfw_r0_fwd_a", fwd_a, 0); tick();

    // Taken branch beats load-use
    do_reset();
    set_id(1, 0, 0, 0, 0, 8, 1, 1); cyc();
    set_id(1, 8, 0, 1, 0, 9, 1, 0); ex_take = 1;
    settle();
    chk("br_pc_we", pc_we, 1);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    tick();
    ex_take = 0; nop();
    settle(); chk("br_stall_cnt", stall_cnt, 0); tick();

    // Memory hold 5 cycles with a pending branch
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_id(1, 5, 0, 1, 0, 6, 1, 0); cyc();
    nop(); ex_take = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_pipe_en", pipe_en, 0);
      chk("hold_ifid_flush", ifid_flush, 0);
      tick();
    end
    mem_ready = 1;
    settle();
    chk("hold_stall_cnt", stall_cnt, 5);
    chk("hold_frozen_fwd_a", fwd_a, 2);
    chk("hold_release_flush", idex_flush, 1);
    chk("hold_mem_err", mem_err, 1);
    tick();
    ex_take = 0; cyc();

    // Timeout: 3 low cycles no error, 4 low cycles error, sticky, rst clears
    do_reset();
    mem_ready = 0; for (int i = 0; i < 3; i++) cyc();
    mem_ready = 1; settle(); chk("to_3_mem_err", mem_err, 0); tick();
    mem_ready = 0; for (int i = 0; i < 4; i++) cyc();
    mem_ready = 1; settle(); chk("to_4_mem_err", mem_err, 1); tick();
    cyc(); cyc();
    settle(); chk("to_sticky", mem_err, 1); tick();
    mem_ready = 0; cyc(); cyc();
    rst = 1; cyc();
    rst = 0; mem_ready = 1;
    settle();
    chk("rst_hold_mem_err", mem_err, 0);
    chk("rst_hold_stall", stall_cnt, 0);
    chk("rst_hold_pc_we", pc_we, 1);
    tick();
    // A single low cycle after reset must not reuse the pre-reset count
    mem_ready = 0; cyc();
    mem_ready = 1; settle(); chk("rst_hold_cnt_clr", mem_err, 0); tick();

    // Stall counter saturation
    do_reset();
    mem_ready = 0; for (int i = 0; i < 10; i++) cyc();
    mem_ready = 1; settle(); chk("sat_stall_cnt", stall_cnt, 7); tick();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      mem_ready = ($urandom_range(0, 5) != 0);
      ex_take   = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It keeps a shadow copy of the destination and control state of the instructions in EX, MEM and WB. From that state it drives PC and pipeline-register write enables, bubbles and flushes, and the EX-stage forwarding selects. It also freezes the whole pipeline while data memory is not ready, and records stall statistics and memory timeout errors.

## Interface
- `CNT_W`, 16: width of the stall-cycle counter.
- `MEM_TIMEOUT`, 64: number of consecutive `mem_ready`-low cycles that sets `mem_err`.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs`, `id_rt` in 5 each: ID source registers.
- `id_use_rs`, `id_use_rt` in 1 each: ID instruction reads rs / rt.
- `id_wr_reg` in 5: ID destination register (after regdst mux).
- `id_regwrite`, `id_memread` in 1 each: ID control bits.
- `ex_take` in 1: branch or jump in EX is taken this cycle.
- `mem_ready` in 1: data memory completes the MEM access this cycle.
- `pc_we`, `ifid_we` out 1 each: PC and IF/ID write enables.
- `ifid_flush`, `idex_flush` out 1 each: load a bubble into IF/ID or ID/EX.
- `pipe_en` out 1: EX/MEM and MEM/WB enable.
- `fwd_a`, `fwd_b` out 2 each: EX operand A/B source. 00 = register file, 01 = WB, 10 = MEM.
- `stall_cnt` out CNT_W: saturating count of cycles with `pc_we`=0 outside reset.
- `mem_err` out 1: sticky memory timeout flag.

## Operation
**Shadow registers.** Each of `ex_*`, `mem_*` and `wb_*` holds valid, rs, rt, wr, regwrite and memread.
- They update only when `pipe_en`=1.
- `ex` loads the ID fields, or a bubble (valid=0) when `idex_flush`=1 or `id_valid`=0.
- `mem` loads `ex`; `wb` loads `mem`.

**Register match.** A match requires valid, regwrite, wr≠0 and an equal register number. Register 0 never matches.

**Load-use hazard (`lu`).** Asserted when all of the following hold:
- `id_valid` and `ex_valid` and `ex_memread`;
- `ex_wr`≠0;
- (`id_use_rs` and `id_rs`=`ex_wr`) or (`id_use_rt` and `id_rt`=`ex_wr`).

**State machine** (`st`):
- **RUN**: moves to HOLD when `mem_ready`=0.
- **HOLD**: returns to RUN when `mem_ready`=1.
- `hold_cnt` increments in HOLD, stops at `MEM_TIMEOUT`, and clears on entering RUN.
- Reaching `MEM_TIMEOUT` sets `mem_err`. Only `rst` clears `mem_err`.

**Output priority** (first match wins):
1. `rst`: `pc_we`=0, `ifid_we`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=0.
2. `mem_ready`=0: `pc_we`=0, `ifid_we`=0, `pipe_en`=0, no flushes. The pipeline freezes and `ex_take` stays pending.
3. `ex_take`: `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1. Any `lu` is ignored because the ID instruction is squashed.
4. `lu`: `pc_we`=0, `ifid_we`=0, `idex_flush`=1, `pipe_en`=1.
5. Otherwise: all enables 1, no flushes.

**Forwarding** (combinational from shadow state):
- `fwd_a`=10 on a MEM match with `ex_rs`; else 01 on a WB match; else 00. MEM wins when both match.
- `fwd_b` is the same rule using `ex_rt`.
- Both are 00 during `rst`.

**Stall counter.** `stall_cnt` increments when `pc_we`=0 and `rst`=0. It saturates at all-ones.

## Timing
- Enables, flushes and forwarding selects are combinational from inputs and shadow state, with zero latency. Shadow registers, `st`, `hold_cnt`, `stall_cnt` and `mem_err` are registered.
- Reset values: shadows invalid, `st`=RUN, `hold_cnt`=0, `stall_cnt`=0, `mem_err`=0.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load sits in MEM and `fwd` selects 10 next cycle.
- A taken branch costs 2 squashed instructions (IF/ID and ID/EX).
- A taken branch during HOLD waits, then flushes in the first cycle `mem_ready`=1.
- `rst` asserted mid-HOLD returns to RUN next cycle and clears `mem_err`.
- `mem_ready` low for exactly `MEM_TIMEOUT` cycles sets `mem_err` on the edge ending the MEM_TIMEOUT-th such cycle; a run of `MEM_TIMEOUT`-1 does not.

## Structure
- **Shared package `cpu_pkg`**: FWD_REG/FWD_WB/FWD_MEM constants, the `st` enum (RUN, HOLD), and the shadow-entry struct.
- **One sub-module `reg_match`**: the 5-bit compare with valid, regwrite and $0 exclusion. Instantiated for rs/rt against EX, MEM and WB.

## Test plan
- **Load-use**: `lw` $8 in EX, ID `add` using rs=8 → `lu`, 1 cycle with `pc_we`=0 and `idex_flush`=1. Next cycle `fwd_a`=10 and `stall_cnt`=1.
- **Double forward**: `add` $3 in MEM and `sub` $3 in WB, EX rs=3 → `fwd_a`=10. With only WB writing $3 → `fwd_a`=01. Destination $0 → 00.
- **Branch**: `ex_take`=1 together with a load-use condition → `ifid_flush`=`idex_flush`=1 and `pc_we`=1. `stall_cnt` unchanged.
- **Memory hold**: `mem_ready`=0 for 5 cycles → `pipe_en`=0, shadows frozen, `stall_cnt`=5. Pending `ex_take` flushes on the release cycle.
- **Timeout**: `MEM_TIMEOUT`=4, `mem_ready` low 3 cycles → `mem_err`=0. Then low 4 cycles → `mem_err`=1, sticky after release, cleared by `rst`.
- **Saturation and reset**: `CNT_W`=3 with 10 stall cycles → `stall_cnt`=7. Assert `rst` mid-HOLD → outputs at reset values next cycle, `st`=RUN.
